// File: rtl/fern_plot_ctrl.sv
// fern_plot_ctrl: port-A framebuffer writer for the barnsley point stream.
// Clears the frame on reset and on every button press, then plots points through a 3-stage pipeline.
module fern_plot_ctrl #(
    parameter int          FB_WIDTH   = 800,
    parameter int          FB_HEIGHT  = 600,
    parameter int          FP_WIDTH   = 25,
    parameter int          FP_INT     = 5,
    parameter int          FRAC_KEEP  = 6,
    parameter int          X_OFFSET   = 400,
    parameter logic [4:0]  PIX_VAL    = 5'b11111,
    parameter logic [19:0] ITER_INIT  = 20'd10000,
    parameter logic [19:0] ITER_STEP  = 20'd10000,
    parameter logic [19:0] ITER_LIMIT = 20'd1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                done,
    input  logic                complete,
    input  logic [FP_WIDTH-1:0] xn,
    input  logic [FP_WIDTH-1:0] yn,
    input  logic                btn,
    output logic [19:0]         iter_max,
    output logic                iter_change,
    output logic                bram_we,
    output logic [18:0]         bram_addr,
    output logic [4:0]          bram_din,
    output logic                clearing,
    output logic                frame_done,
    output logic [19:0]         plot_cnt,
    output logic [15:0]         oob_cnt
);
    localparam int PW   = FP_INT + FRAC_KEEP;
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;

    typedef enum logic [1:0] {CLEAR, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [18:0]          clr_addr_q, clr_addr_d;
    logic [19:0]          iter_max_q, iter_max_d;
    logic                 iter_change_q, iter_change_d;
    logic                 bram_we_q, bram_we_d;
    logic [18:0]          bram_addr_q, bram_addr_d;
    logic [4:0]           bram_din_q, bram_din_d;
    logic [19:0]          plot_cnt_q, plot_cnt_d;
    logic [15:0]          oob_cnt_q, oob_cnt_d;
    logic [2:0]           btn_sync_q, btn_sync_d;
    logic                 v1_q, v1_d, v2_q, v2_d, ok2_q, ok2_d;
    logic signed [PW-1:0] x1_q, x1_d, y1_q, y1_d;
    logic signed [11:0]   col_q, col_d, row_q, row_d;
    logic                 press;
    logic [20:0]          iter_sum;
    logic                 unused_frac;

    assign unused_frac = ^{xn[FP_WIDTH-PW-1:0], yn[FP_WIDTH-PW-1:0]};

    always_comb begin
        btn_sync_d    = {btn_sync_q[1:0], btn};
        press         = btn_sync_q[1] & ~btn_sync_q[2];
        iter_sum      = {1'b0, iter_max_q} + {1'b0, ITER_STEP};
        v1_d          = done & ~complete & (state_q == RUN);
        x1_d          = xn[FP_WIDTH-1 -: PW];
        y1_d          = yn[FP_WIDTH-1 -: PW];
        v2_d          = v1_q;
        col_d         = 12'(x1_q) + 12'(X_OFFSET);
        row_d         = 12'(FB_HEIGHT - 1) - 12'(y1_q);
        ok2_d         = ~col_d[11] & ~row_d[11] & (col_d < 12'(FB_WIDTH)) & (row_d < 12'(FB_HEIGHT));
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        iter_max_d    = iter_max_q;
        iter_change_d = 1'b0;
        bram_we_d     = v2_q & ok2_q;
        bram_addr_d   = bram_we_d ? 19'(row_q) * 19'(FB_WIDTH) + 19'(col_q) : '0;
        bram_din_d    = bram_we_d ? PIX_VAL : '0;
        plot_cnt_d    = plot_cnt_q + 20'(v2_q & ok2_q & ~&plot_cnt_q);
        oob_cnt_d     = oob_cnt_q + 16'(v2_q & ~ok2_q & ~&oob_cnt_q);
        // clr_addr runs one past the last pixel so the final write lands while still in CLEAR
        if (state_q == CLEAR) begin
            if (clr_addr_q == 19'(NPIX)) begin
                state_d       = RUN;
                iter_change_d = 1'b1;
                plot_cnt_d    = '0;
                oob_cnt_d     = '0;
            end else begin
                clr_addr_d  = clr_addr_q + 19'd1;
                bram_we_d   = 1'b1;
                bram_addr_d = clr_addr_q;
                bram_din_d  = '0;
            end
        end else if (state_q == RUN && complete) begin
            state_d = DONE;
        end
        if (press) begin
            state_d       = CLEAR;
            clr_addr_d    = '0;
            iter_max_d    = iter_sum > {1'b0, ITER_LIMIT} ? ITER_INIT : iter_sum[19:0];
            iter_change_d = 1'b0;
            v1_d          = 1'b0;
            v2_d          = 1'b0;
            bram_we_d     = 1'b0;
            bram_addr_d   = '0;
            bram_din_d    = '0;
            plot_cnt_d    = plot_cnt_q;
            oob_cnt_d     = oob_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            iter_max_q    <= ITER_INIT;
            iter_change_q <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            plot_cnt_q    <= '0;
            oob_cnt_q     <= '0;
            btn_sync_q    <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            ok2_q         <= 1'b0;
            x1_q          <= '0;
            y1_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            iter_max_q    <= iter_max_d;
            iter_change_q <= iter_change_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            plot_cnt_q    <= plot_cnt_d;
            oob_cnt_q     <= oob_cnt_d;
            btn_sync_q    <= btn_sync_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            ok2_q         <= ok2_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            col_q         <= col_d;
            row_q         <= row_d;
        end
    end

    assign iter_max    = iter_max_q;
    assign iter_change = iter_change_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign clearing    = (state_q == CLEAR);
    assign frame_done  = (state_q == DONE);
    assign plot_cnt    = plot_cnt_q;
    assign oob_cnt     = oob_cnt_q;
endmodule

// File: tb/tb_fern_plot_ctrl.sv
// tb_fern_plot_ctrl: scoreboard bench for fern_plot_ctrl on a reduced 100x40 frame
// (1 px = 2^-3) so each clear sweep is short.
module tb_fern_plot_ctrl;
    localparam int         W    = 100;
    localparam int         H    = 40;
    localparam int         XOFF = 50;
    localparam int         FK   = 3;
    localparam int         SH   = 25 - 5 - FK;
    localparam int         NPIX = W * H;
    localparam logic [4:0] PIX  = 5'b11111;

    logic        clk = 0, reset = 0, done = 0, complete = 0, btn = 0;
    logic [24:0] xn = '0, yn = '0;
    logic [19:0] iter_max, plot_cnt;
    logic        iter_change, bram_we, clearing, frame_done;
    logic [18:0] bram_addr;
    logic [4:0]  bram_din;
    logic [15:0] oob_cnt;

    int pass_cnt = 0, total_cnt = 0, cyc = 0, plot_exp = 0, oob_exp = 0, mon_exp = 0;
    int exp_q[$];
    int wr_cyc[$];

    fern_plot_ctrl #(.FB_WIDTH(W), .FB_HEIGHT(H), .X_OFFSET(XOFF), .FRAC_KEEP(FK),
                     .ITER_LIMIT(20'd30000)) dut (
        .clk(clk), .reset(reset), .done(done), .complete(complete), .xn(xn), .yn(yn), .btn(btn),
        .iter_max(iter_max), .iter_change(iter_change), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .clearing(clearing), .frame_done(frame_done),
        .plot_cnt(plot_cnt), .oob_cnt(oob_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && bram_we && !clearing) begin
            total_cnt++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                $display("FAIL plot_write: got write addr=%0d din=%0d, want no write", bram_addr, bram_din);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bram_addr !== 19'(mon_exp) || bram_din !== PIX)
                    $display("FAIL plot_write: got addr=%0d din=%0d, want addr=%0d din=%0d",
                             bram_addr, bram_din, mon_exp, PIX);
                else pass_cnt++;
            end
        end
    end

    function automatic int fx(input int k);
        return k * (1 << SH) + int'($urandom_range(0, (1 << SH) - 1));
    endfunction

    task automatic send_point(input int xi, input int yi, input bit push);
        int col, row;
        col = (xi >>> SH) + XOFF;
        row = H - 1 - (yi >>> SH);
        if (push) begin
            if (col >= 0 && col < W && row >= 0 && row < H) begin
                exp_q.push_back(row * W + col);
                plot_exp++;
            end else oob_exp++;
        end
        xn = 25'(xi);
        yn = 25'(yi);
        done = 1;
        @(posedge clk);
        #1 done = 0;
    endtask

    task automatic do_press();
        @(posedge clk);
        #1 btn = 0;
        repeat (3) @(posedge clk);
        #1 btn = 1;
    endtask

    task automatic wait_clear_start(input bit quiet, input string tag);
        bit found = 0;
        int noise = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bram_we === 1 && clearing === 1 && bram_addr === 0) found = 1;
            else if (bram_we !== 0) noise++;
        end
        total_cnt++;
        if (!found) $display("FAIL %s_clear_start: got no addr-0 clear write in 12 cycles, want restart at 0", tag);
        else pass_cnt++;
        if (quiet) begin
            total_cnt++;
            if (noise != 0) $display("FAIL %s_quiet: got %0d stray writes before sweep, want 0", tag, noise);
            else pass_cnt++;
        end
    endtask

    task automatic finish_clear(input string tag);
        int bad = 0, first_bad = -1;
        for (int i = 1; i < NPIX; i++) begin
            @(negedge clk);
            if (bram_we !== 1 || clearing !== 1 || bram_addr !== 19'(i) || bram_din !== 0) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL %s_sweep: got %0d bad cycles (first at index %0d), want 0", tag, bad, first_bad);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (iter_change !== 1 || clearing !== 0 || bram_we !== 0)
            $display("FAIL %s_end: got iter_change=%b clearing=%b we=%b, want 1 0 0", tag, iter_change, clearing, bram_we);
        else pass_cnt++;
        total_cnt++;
        if (plot_cnt !== 0 || oob_cnt !== 0)
            $display("FAIL %s_cnt_zero: got plot=%0d oob=%0d, want 0 0", tag, plot_cnt, oob_cnt);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (iter_change !== 0) $display("FAIL %s_pulse: got iter_change=%b after one cycle, want 0", tag, iter_change);
        else pass_cnt++;
        plot_exp = 0;
        oob_exp = 0;
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d writes missing, want 0", tag, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (plot_cnt !== 20'(plot_exp) || oob_cnt !== 16'(oob_exp))
            $display("FAIL %s_counts: got plot=%0d oob=%0d, want %0d %0d", tag, plot_cnt, oob_cnt, plot_exp, oob_exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bram_we !== 0 || bram_addr !== 0 || bram_din !== 0 || iter_change !== 0)
            $display("FAIL reset_port: got we=%b addr=%0d din=%0d ic=%b, want 0 0 0 0", bram_we, bram_addr, bram_din, iter_change);
        else pass_cnt++;
        total_cnt++;
        if (clearing !== 1 || frame_done !== 0)
            $display("FAIL reset_state: got clearing=%b frame_done=%b, want 1 0", clearing, frame_done);
        else pass_cnt++;
        total_cnt++;
        if (iter_max !== 20'd10000 || plot_cnt !== 0 || oob_cnt !== 0)
            $display("FAIL reset_regs: got iter_max=%0d plot=%0d oob=%0d, want 10000 0 0", iter_max, plot_cnt, oob_cnt);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1;
        wait_clear_start(1, "reset");
        finish_clear("reset");
    endtask

    task automatic test_origin();
        bit ok;
        send_point(fx(0), fx(0), 1);
        @(negedge clk);
        ok = (bram_we === 0);
        @(negedge clk);
        ok &= (bram_we === 0);
        @(negedge clk);
        ok &= (bram_we === 1 && bram_addr === 19'((H - 1) * W + XOFF) && bram_din === PIX);
        total_cnt++;
        if (!ok) $display("FAIL origin_latency: got we=%b addr=%0d at 3rd cycle (or early write), want we=1 addr=%0d",
                          bram_we, bram_addr, (H - 1) * W + XOFF);
        else pass_cnt++;
        drain("origin");
    endtask

    task automatic test_oob();
        send_point(7 << 20, 0, 1);
        send_point(0, 1 << 20, 1);
        drain("oob");
    endtask

    task automatic test_back_to_back();
        wr_cyc.delete();
        send_point(fx(-50), fx(39), 1);
        send_point(fx(49), fx(0), 1);
        send_point(fx(10), fx(5), 1);
        send_point(fx(-3), fx(0), 1);
        send_point(fx(25), fx(20), 1);
        drain("b2b");
        total_cnt++;
        if (wr_cyc.size() != 5 || wr_cyc[4] - wr_cyc[0] != 4)
            $display("FAIL b2b_spacing: got %0d writes spanning %0d cycles, want 5 spanning 4",
                     wr_cyc.size(), wr_cyc.size() == 5 ? wr_cyc[4] - wr_cyc[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_squash();
        do_press();
        send_point(fx(3), fx(4), 0);
        send_point(fx(-7), fx(9), 0);
        wait_clear_start(1, "squash");
        total_cnt++;
        if (iter_max !== 20'd20000) $display("FAIL squash_iter: got iter_max=%0d, want 20000", iter_max);
        else pass_cnt++;
        total_cnt++;
        if (plot_cnt !== 20'(plot_exp) || oob_cnt !== 16'(oob_exp))
            $display("FAIL squash_counts: got plot=%0d oob=%0d, want %0d %0d", plot_cnt, oob_cnt, plot_exp, oob_exp);
        else pass_cnt++;
        finish_clear("squash");
    endtask

    task automatic test_complete();
        send_point(fx(5), fx(5), 1);
        complete = 1;
        @(posedge clk);
        #1 complete = 0;
        @(negedge clk);
        total_cnt++;
        if (frame_done !== 1 || clearing !== 0)
            $display("FAIL complete_state: got frame_done=%b clearing=%b, want 1 0", frame_done, clearing);
        else pass_cnt++;
        send_point(fx(10), fx(10), 0);
        drain("complete");
        do_press();
        wait_clear_start(1, "done_press");
        total_cnt++;
        if (iter_max !== 20'd30000 || frame_done !== 0)
            $display("FAIL done_press_iter: got iter_max=%0d frame_done=%b, want 30000 0", iter_max, frame_done);
        else pass_cnt++;
        finish_clear("done_press");
    endtask

    task automatic test_wrap();
        do_press();
        wait_clear_start(1, "wrap");
        total_cnt++;
        if (iter_max !== 20'd10000) $display("FAIL wrap_iter: got iter_max=%0d, want 10000", iter_max);
        else pass_cnt++;
        repeat (200) @(negedge clk);
        do_press();
        wait_clear_start(0, "restart");
        total_cnt++;
        if (iter_max !== 20'd20000) $display("FAIL restart_iter: got iter_max=%0d, want 20000", iter_max);
        else pass_cnt++;
        finish_clear("restart");
    endtask

    initial begin
        test_reset();
        test_origin();
        test_oob();
        test_back_to_back();
        test_squash();
        test_complete();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
